// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  localparam int unsigned XLEN = 64;
  localparam int unsigned ILEN = 32;
  localparam logic [XLEN-1:0] RESET_PC = 64'h8000_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] raw_instr;
  } fetch_data_t;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] target;
  } redirect_t;

  // mret > jr > jump > branch; targets are word aligned
  function automatic redirect_t select_redirect(
    input logic            is_mret,
    input logic [XLEN-1:0] mepc,
    input logic            jr,
    input logic [XLEN-1:0] pcjr,
    input logic            jump,
    input logic [XLEN-1:0] pcjump,
    input logic            branch_taken,
    input logic [XLEN-1:0] pcbranch
  );
    redirect_t       r;
    logic [XLEN-1:0] t;
    if (is_mret)   t = mepc;
    else if (jr)   t = pcjr;
    else if (jump) t = pcjump;
    else           t = pcbranch;
    r.valid  = is_mret | jr | jump | branch_taken;
    r.target = t & ~XLEN'(3);
    return r;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush and occupancy count; pointers carry an extra wrap bit.
module fetch_fifo #(
  parameter int unsigned WIDTH = 96,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop  = pop_i & ~empty_o;
  // a pop in the same cycle frees the slot for a push at full
  assign do_push = push_i & (~full | do_pop);
  assign count_o = wr_ptr_q - rd_ptr_q;
  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (do_push && !flush_i) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, issues credit-limited instruction reads and buffers
// responses for decode; redirects flush the buffer and drop in-flight responses.
module fetch_unit #(
  parameter logic [63:0] RESET_PC        = fetch_pkg::RESET_PC,
  parameter int unsigned FIFO_DEPTH      = 4,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        branch_taken,
  input  logic [63:0] pcbranch,
  input  logic        jump,
  input  logic [63:0] pcjump,
  input  logic        jr,
  input  logic [63:0] pcjr,
  input  logic        is_mret,
  input  logic [63:0] mepc,
  output logic        ireq_valid,
  output logic [63:0] ireq_addr,
  input  logic        ireq_ready,
  input  logic        iresp_valid,
  input  logic [31:0] iresp_data,
  output logic        f_valid,
  output logic [63:0] f_pc,
  output logic [31:0] f_raw_instr,
  input  logic        f_ready
);
  import fetch_pkg::*;

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned OW = $clog2(MAX_OUTSTANDING) + 1;
  localparam int unsigned DW = $bits(fetch_data_t);

  redirect_t       redir;
  fetch_data_t     ib_wdata, ib_rdata;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pend_target_q, pend_target_d;
  logic [XLEN-1:0] rq_pc;
  logic            ireq_valid_q, ireq_valid_d;
  logic            pend_q, pend_d;
  logic [OW-1:0]   drop_cnt_q, drop_cnt_d;
  logic [OW-1:0]   outstanding, out_next;
  logic [CW-1:0]   ib_count, ib_count_next;
  logic            hs, held, resp_ok, resp_drop;
  logic            ib_push, ib_pop, ib_empty, rq_empty, credit_ok;

  assign redir = select_redirect(is_mret, mepc, jr, pcjr, jump, pcjump,
                                 branch_taken, pcbranch);

  assign hs   = ireq_valid_q & ireq_ready;
  assign held = ireq_valid_q & ~ireq_ready;
  // a response with nothing in flight is stale (e.g. issued before reset)
  assign resp_ok   = iresp_valid & ~rq_empty;
  assign resp_drop = redir.valid | (drop_cnt_q != '0);
  assign ib_push   = resp_ok & ~resp_drop;
  assign ib_pop    = ~ib_empty & f_ready;

  assign out_next      = outstanding + OW'(hs) - OW'(resp_ok);
  assign ib_count_next = redir.valid ? '0 : ib_count + CW'(ib_push) - CW'(ib_pop);
  assign credit_ok     = (32'(out_next) < MAX_OUTSTANDING) &&
                         (32'(out_next) + 32'(ib_count_next) < FIFO_DEPTH);

  assign ib_wdata.pc        = rq_pc;
  assign ib_wdata.raw_instr = iresp_data;

  // Address of every accepted request, popped by its in-order response
  fetch_fifo #(.WIDTH(XLEN), .DEPTH(MAX_OUTSTANDING)) u_req_q (
    .clk     (clk),
    .rst_n   (reset),
    .flush_i (1'b0),
    .push_i  (hs),
    .wdata_i (pc_q),
    .pop_i   (resp_ok),
    .rdata_o (rq_pc),
    .empty_o (rq_empty),
    .count_o (outstanding)
  );

  fetch_fifo #(.WIDTH(DW), .DEPTH(FIFO_DEPTH)) u_ibuf (
    .clk     (clk),
    .rst_n   (reset),
    .flush_i (redir.valid),
    .push_i  (ib_push),
    .wdata_i (ib_wdata),
    .pop_i   (ib_pop),
    .rdata_o (ib_rdata),
    .empty_o (ib_empty),
    .count_o (ib_count)
  );

  always_comb begin
    pc_d          = pc_q;
    pend_d        = pend_q;
    pend_target_d = pend_target_q;
    drop_cnt_d    = drop_cnt_q;
    if (resp_ok && drop_cnt_q != '0) drop_cnt_d = drop_cnt_q - OW'(1);
    if (hs) begin
      if (pend_q) begin
        pc_d       = pend_target_q;
        pend_d     = 1'b0;
        drop_cnt_d = drop_cnt_d + OW'(1);
      end else begin
        pc_d = pc_q + XLEN'(4);
      end
    end
    // every request still in flight after this cycle belongs to the old path
    if (redir.valid) begin
      drop_cnt_d = out_next;
      if (held) begin
        pend_d        = 1'b1;
        pend_target_d = redir.target;
      end else begin
        pc_d   = redir.target;
        pend_d = 1'b0;
      end
    end
    ireq_valid_d = held | credit_ok;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q          <= RESET_PC;
      ireq_valid_q  <= 1'b0;
      pend_q        <= 1'b0;
      pend_target_q <= '0;
      drop_cnt_q    <= '0;
    end else begin
      pc_q          <= pc_d;
      ireq_valid_q  <= ireq_valid_d;
      pend_q        <= pend_d;
      pend_target_q <= pend_target_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

  assign ireq_valid  = ireq_valid_q;
  assign ireq_addr   = pc_q;
  assign f_valid     = ~ib_empty;
  assign f_pc        = ib_rdata.pc;
  assign f_raw_instr = ib_rdata.raw_instr;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with an in-order memory model (data = ~addr[31:0]).
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        branch_taken, jump, jr, is_mret;
  logic [63:0] pcbranch, pcjump, pcjr, mepc;
  logic        ireq_valid;
  logic [63:0] ireq_addr;
  logic        ireq_ready;
  logic        iresp_valid = 1'b0;
  logic [31:0] iresp_data = '0;
  logic        f_valid;
  logic [63:0] f_pc;
  logic [31:0] f_raw_instr;
  logic        f_ready;

  int total = 0;
  int bad   = 0;

  logic [63:0] mq[$];
  bit          mem_go = 1'b0;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk          (clk),
    .reset        (reset),
    .branch_taken (branch_taken),
    .pcbranch     (pcbranch),
    .jump         (jump),
    .pcjump       (pcjump),
    .jr           (jr),
    .pcjr         (pcjr),
    .is_mret      (is_mret),
    .mepc         (mepc),
    .ireq_valid   (ireq_valid),
    .ireq_addr    (ireq_addr),
    .ireq_ready   (ireq_ready),
    .iresp_valid  (iresp_valid),
    .iresp_data   (iresp_data),
    .f_valid      (f_valid),
    .f_pc         (f_pc),
    .f_raw_instr  (f_raw_instr),
    .f_ready      (f_ready)
  );

  // In-order memory: 1-cycle latency while mem_go, otherwise requests queue up
  always @(posedge clk) begin : mem_model
    logic [63:0] a;
    if (ireq_valid === 1'b1 && ireq_ready === 1'b1) mq.push_back(ireq_addr);
    iresp_valid <= 1'b0;
    if (mem_go && mq.size() > 0) begin
      a = mq.pop_front();
      iresp_valid <= 1'b1;
      iresp_data  <= ~a[31:0];
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_reset(input bit keep_mem);
    reset = 1'b0;
    branch_taken = 1'b0; jump = 1'b0; jr = 1'b0; is_mret = 1'b0;
    #1;
    chk("rst_ireq_valid", 64'(ireq_valid), 64'd0);
    chk("rst_f_valid", 64'(f_valid), 64'd0);
    chk("rst_ireq_addr", ireq_addr, 64'h8000_0000);
    if (!keep_mem) mq.delete();
    repeat (2) tick();
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    branch_taken = 1'b0; jump = 1'b0; jr = 1'b0; is_mret = 1'b0;
    pcbranch = '0; pcjump = '0; pcjr = '0; mepc = '0;
    ireq_ready = 1'b0; f_ready = 1'b0;
    tick();

    // Straight-line fetch, 1-cycle memory
    ireq_ready = 1'b1; f_ready = 1'b1; mem_go = 1'b1;
    do_reset(1'b0);
    tick();
    chk("a_req0_valid", 64'(ireq_valid), 64'd1);
    chk("a_req0_addr", ireq_addr, 64'h8000_0000);
    tick();
    chk("a_req1_addr", ireq_addr, 64'h8000_0004);
    chk("a_fvalid_early", 64'(f_valid), 64'd0);
    tick();
    chk("a_fvalid_first", 64'(f_valid), 64'd1);
    chk("a_pc0", f_pc, 64'h8000_0000);
    chk("a_instr0", 64'(f_raw_instr), 64'h7FFF_FFFF);
    chk("a_req2_addr", ireq_addr, 64'h8000_0008);
    tick();
    chk("a_pc1", f_pc, 64'h8000_0004);
    tick();
    chk("a_pc2", f_pc, 64'h8000_0008);
    chk("a_instr2", 64'(f_raw_instr), 64'h7FFF_FFF7);

    // Decode stalled: buffer fills to the credit limit and the head holds
    f_ready = 1'b0;
    do_reset(1'b0);
    for (int i = 0; i < 12; i++) begin
      tick();
      if (i >= 2) chk("b_head_hold", f_pc, 64'h8000_0000);
    end
    chk("b_credit_stop", 64'(ireq_valid), 64'd0);
    chk("b_fvalid_full", 64'(f_valid), 64'd1);
    f_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("b_pop_valid", 64'(f_valid), 64'd1);
      chk("b_pop_pc", f_pc, 64'h8000_0004 + 64'(4 * k));
    end

    // jump with two requests outstanding
    mem_go = 1'b0;
    do_reset(1'b0);
    repeat (3) tick();
    chk("c_two_outstanding", 64'(ireq_valid), 64'd0);
    jump = 1'b1; pcjump = 64'h8000_0100; mem_go = 1'b1;
    tick();
    jump = 1'b0;
    chk("c_redir_fvalid", 64'(f_valid), 64'd0);
    chk("c_redir_noreq", 64'(ireq_valid), 64'd0);
    tick();
    chk("c_tgt_valid", 64'(ireq_valid), 64'd1);
    chk("c_tgt_addr", ireq_addr, 64'h8000_0100);
    chk("c_drop0", 64'(f_valid), 64'd0);
    tick();
    chk("c_drop1", 64'(f_valid), 64'd0);
    tick();
    chk("c_tgt_fvalid", 64'(f_valid), 64'd1);
    chk("c_tgt_pc", f_pc, 64'h8000_0100);

    // jr while a request is held unaccepted
    do_reset(1'b0);
    repeat (5) tick();
    chk("d_pre_addr", ireq_addr, 64'h8000_0010);
    ireq_ready = 1'b0;
    tick();
    chk("d_held_valid", 64'(ireq_valid), 64'd1);
    jr = 1'b1; pcjr = 64'h8000_0203;
    tick();
    jr = 1'b0;
    chk("d_held_addr0", ireq_addr, 64'h8000_0010);
    chk("d_held_valid2", 64'(ireq_valid), 64'd1);
    chk("d_flush", 64'(f_valid), 64'd0);
    tick();
    chk("d_held_addr1", ireq_addr, 64'h8000_0010);
    ireq_ready = 1'b1;
    tick();
    chk("d_tgt_addr", ireq_addr, 64'h8000_0200);
    chk("d_tgt_valid", 64'(ireq_valid), 64'd1);
    chk("d_no_out0", 64'(f_valid), 64'd0);
    tick();
    chk("d_held_dropped", 64'(f_valid), 64'd0);
    chk("d_tgt_addr1", ireq_addr, 64'h8000_0204);
    tick();
    chk("d_tgt_fvalid", 64'(f_valid), 64'd1);
    chk("d_tgt_pc", f_pc, 64'h8000_0200);
    chk("d_tgt_instr", 64'(f_raw_instr), 64'h7FFF_FDFF);

    // mret beats a simultaneous branch
    do_reset(1'b0);
    tick();
    chk("e_req0_addr", ireq_addr, 64'h8000_0000);
    branch_taken = 1'b1; pcbranch = 64'h8000_0040;
    is_mret = 1'b1; mepc = 64'h8000_1000;
    tick();
    branch_taken = 1'b0; is_mret = 1'b0;
    chk("e_prio_valid", 64'(ireq_valid), 64'd1);
    chk("e_prio_addr", ireq_addr, 64'h8000_1000);
    tick();
    chk("e_old_dropped", 64'(f_valid), 64'd0);
    tick();
    chk("e_tgt_fvalid", 64'(f_valid), 64'd1);
    chk("e_tgt_pc", f_pc, 64'h8000_1000);

    // Reset with two requests outstanding; their late responses must be ignored
    mem_go = 1'b0;
    tick();
    tick();
    chk("f_two_outstanding", 64'(ireq_valid), 64'd0);
    ireq_ready = 1'b0;
    do_reset(1'b1);
    tick();
    chk("f_first_valid", 64'(ireq_valid), 64'd1);
    chk("f_first_addr", ireq_addr, 64'h8000_0000);
    mem_go = 1'b1;
    tick();
    chk("f_stale0", 64'(f_valid), 64'd0);
    tick();
    chk("f_stale1", 64'(f_valid), 64'd0);
    tick();
    chk("f_stale2", 64'(f_valid), 64'd0);
    chk("f_held_addr", ireq_addr, 64'h8000_0000);
    ireq_ready = 1'b1;
    tick();
    tick();
    chk("f_fvalid", 64'(f_valid), 64'd1);
    chk("f_pc", f_pc, 64'h8000_0000);
    chk("f_instr", 64'(f_raw_instr), 64'h7FFF_FFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
